penc_pend_arb: RTL and testbench
================================

// Module: penc_pend_arb
// PURPOSE
//   Parametrised sticky-request priority encoder with registered valid/ready output.
//   Captures N request lines into a pending register and presents the highest pending index.
//   Holds that index until a downstream consumer accepts it, then clears that pending bit.
//   Sits between interrupt/event sources and a single sequential consumer.
// PARAMETERS
//   N      8   number of request lines (2..64)
//   IDX_W  3   index width; must equal $clog2(N)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   req        in   N      request pulses/levels; bit i = source i
//   out_idx    out  IDX_W  highest-priority pending index (valid when out_valid=1)
//   out_valid  out  1      out_idx holds a pending request
//   out_ready  in   1      consumer accepts out_idx when out_valid & out_ready
//   pending    out  N      current pending register
//   ovf        out  1      sticky: a request hit an already-pending, un-acked bit
// BEHAVIOUR
//   - Reset: rst=1 at an edge -> pending=0, out_valid=0, out_idx=0, ovf=0.
//     Reset overrides all activity, including a handshake in the same cycle.
//   - ack = out_valid & out_ready. ack_mask = onehot(out_idx) if ack, else 0.
//   - next_pend = (pending & ~ack_mask) | req.
//     A request on the acked bit in the same cycle re-sets it: set wins over clear.
//   - pending <= next_pend every cycle.
//   - Output register loads only when (!out_valid | out_ready):
//     - out_valid <= |eff_pend; out_idx <= index of the highest set bit of eff_pend.
//     - If eff_pend == 0, out_idx <= 0.
//     - eff_pend = next_pend, gated per CONFIGURATION.
//   - While out_valid=1 and out_ready=0, out_idx and out_valid are frozen.
//     New or higher-priority requests only accumulate in pending.
//   - Latency: req bit set at edge k (idle output) -> out_valid=1, out_idx set after edge k.
//   - Back-to-back: with out_ready=1 held, one index is retired per cycle.
//     Order is highest first; full drain of K pending bits takes K cycles.
//   - Priority: highest index wins (bit N-1 highest).
//     Output is not re-evaluated mid-hold, so no preemption while stalled.
//   - ovf <= ovf | |(req & pending & ~ack_mask). ovf is cleared only by rst.
//   - out_ready while out_valid=0 is ignored.
//   - req=all-ones with N=8: out_idx sequence is 7,6,...,0 under continuous ready.
//   - Fully synchronous. No combinational path from req or out_ready to any output.
// CONFIGURATION
//   PENC_MASK_EN defined:
//     - Adds input port `mask` [N-1:0], placed after req.
//     - eff_pend = next_pend & mask.
//     - Masked bits still latch into pending and still raise ovf, but are never presented.
//     - Unmasking a pending bit makes it eligible at the next output load.
//     - A mask change does not alter an out_idx already frozen under stall.
//   PENC_MASK_EN undefined:
//     - No mask port; eff_pend = next_pend.
// TESTING
//   1 reset: drive req=8'hFF with rst=1 for 2 cycles -> pending=0, out_valid=0, ovf=0 throughout.
//   2 single: req=8'h10 one cycle, out_ready=1 -> out_valid=1, out_idx=4 next cycle;
//     following cycle out_valid=0, pending=0.
//   3 stall/priority: pend bit2, out_ready=0; then req=8'h80 -> out_idx stays 2, pending=8'h84.
//     Raise ready -> 2 then 7 retired on consecutive cycles.
//   4 drain: req=8'hFF one cycle, ready=1 -> out_idx 7..0 over 8 cycles, then out_valid=0.
//   5 set-wins/ovf: out_idx=3 acked while req=8'h08 -> pending bit3 stays 1, ovf=0.
//     Then req=8'h08 again with no ack -> ovf=1 until rst.
//   6 PENC_MASK_EN: mask=8'h0F, req=8'hF1 -> out_idx=0, pending=8'hF1.
//     Set mask=8'hFF -> out_idx=7 at the next load.

Source files
------------

// File: rtl/penc_pend_arb.sv
// Sticky-request priority encoder with a registered valid/ready output stage.
// Optional mask input for presentation gating when PENC_MASK_EN is defined.
module penc_pend_arb #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
`ifdef PENC_MASK_EN
    input  logic [N-1:0]     mask,
`endif
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             ovf
);

    logic             ack;
    logic             load;
    logic [N-1:0]     ack_mask;
    logic [N-1:0]     next_pend;
    logic [N-1:0]     eff_pend;
    logic [IDX_W-1:0] enc_idx;

    always_comb begin
        ack      = out_valid & out_ready;
        load     = !out_valid | out_ready;
        ack_mask = '0;
        if (ack) begin
            ack_mask[out_idx] = 1'b1;
        end
        // A request on the bit being retired re-arms it in the same cycle.
        next_pend = (pending & ~ack_mask) | req;
`ifdef PENC_MASK_EN
        eff_pend  = next_pend & mask;
`else
        eff_pend  = next_pend;
`endif
        enc_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eff_pend[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ovf       <= 1'b0;
        end else begin
            pending <= next_pend;
            ovf     <= ovf | (|(req & pending & ~ack_mask));
            // Output only re-evaluates when empty or being consumed; no preemption while stalled.
            if (load) begin
                out_valid <= |eff_pend;
                out_idx   <= enc_idx;
            end
        end
    end

endmodule

// File: tb/tb_penc_pend_arb.sv
// Directed table-driven bench for penc_pend_arb (N=8), plus hand-written drain and mask sequences.
module tb_penc_pend_arb;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       ovf;
`ifdef PENC_MASK_EN
    logic [7:0] mask;
`endif

    int checks = 0;
    int errors = 0;

    penc_pend_arb #(.N(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef PENC_MASK_EN
        .mask      (mask),
`endif
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
        logic       eo;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] q, input logic rd,
                       input logic ev, input logic [2:0] ei, input logic [7:0] ep,
                       input logic eo, input string nm);
        vec_t v;
        v.rst = r; v.req = q; v.rdy = rd;
        v.ev = ev; v.ei = ei; v.ep = ep; v.eo = eo; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic ev, input logic [2:0] ei,
                             input logic [7:0] ep, input logic eo);
        check({nm, ".valid"},   {7'd0, out_valid}, {7'd0, ev});
        check({nm, ".idx"},     {5'd0, out_idx},   {5'd0, ei});
        check({nm, ".pending"}, pending,           ep);
        check({nm, ".ovf"},     {7'd0, ovf},       {7'd0, eo});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] hi_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    initial begin
        logic [7:0] pm;
        int         retired;

        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
`ifdef PENC_MASK_EN
        mask = 8'hFF;
`endif

        //   rst  req    rdy  valid idx pending ovf
        add(1, 8'hFF, 0,   0, 3'd0, 8'h00, 0, "reset0");
        add(1, 8'hFF, 0,   0, 3'd0, 8'h00, 0, "reset1");
        add(0, 8'h10, 1,   1, 3'd4, 8'h10, 0, "single_load");
        add(0, 8'h00, 1,   0, 3'd0, 8'h00, 0, "single_retire");
        add(0, 8'h04, 0,   1, 3'd2, 8'h04, 0, "stall_load2");
        add(0, 8'h80, 0,   1, 3'd2, 8'h84, 0, "stall_hold");
        add(0, 8'h00, 1,   1, 3'd7, 8'h80, 0, "stall_retire2");
        add(0, 8'h00, 1,   0, 3'd0, 8'h00, 0, "stall_retire7");
        add(0, 8'hFF, 1,   1, 3'd7, 8'hFF, 0, "drain_load");
        add(0, 8'h00, 1,   1, 3'd6, 8'h7F, 0, "drain6");
        add(0, 8'h00, 1,   1, 3'd5, 8'h3F, 0, "drain5");
        add(0, 8'h00, 1,   1, 3'd4, 8'h1F, 0, "drain4");
        add(0, 8'h00, 1,   1, 3'd3, 8'h0F, 0, "drain3");
        add(0, 8'h00, 1,   1, 3'd2, 8'h07, 0, "drain2");
        add(0, 8'h00, 1,   1, 3'd1, 8'h03, 0, "drain1");
        add(0, 8'h00, 1,   1, 3'd0, 8'h01, 0, "drain0");
        add(0, 8'h00, 1,   0, 3'd0, 8'h00, 0, "drain_empty");
        add(0, 8'h08, 0,   1, 3'd3, 8'h08, 0, "setwin_load");
        add(0, 8'h08, 1,   1, 3'd3, 8'h08, 0, "setwin_ack");
        add(0, 8'h08, 0,   1, 3'd3, 8'h08, 1, "ovf_raise");
        add(0, 8'h00, 0,   1, 3'd3, 8'h08, 1, "ovf_sticky");
        add(0, 8'h00, 1,   0, 3'd0, 8'h00, 1, "ovf_after_drain");
        add(0, 8'h20, 0,   1, 3'd5, 8'h20, 1, "pre_reset_load");
        add(1, 8'h01, 1,   0, 3'd0, 8'h00, 0, "reset_over_ack");

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].rst; req = vecs[k].req; out_ready = vecs[k].rdy;
            step();
            check_all(vecs[k].name, vecs[k].ev, vecs[k].ei, vecs[k].ep, vecs[k].eo);
            @(negedge clk);
        end

        // Mixed pattern drained highest-first against a small model.
        rst = 1'b0; req = 8'hA5; out_ready = 1'b1;
        pm = 8'hA5;
        step();
        req = 8'h00;
        retired = 0;
        for (int k = 0; k < 10; k++) begin
            if (pm == 8'h00) break;
            check("mix.valid", {7'd0, out_valid}, 8'h01);
            check("mix.idx", {5'd0, out_idx}, {5'd0, hi_bit(pm)});
            check("mix.pending", pending, pm);
            pm[hi_bit(pm)] = 1'b0;
            retired++;
            @(negedge clk);
            step();
        end
        check("mix.retired", 8'(retired), 8'd4);
        check("mix.empty_valid", {7'd0, out_valid}, 8'h00);
        check("mix.empty_pending", pending, 8'h00);
        @(negedge clk);

`ifdef PENC_MASK_EN
        rst = 1'b1; req = 8'h00; out_ready = 1'b0; mask = 8'hFF;
        step();
        @(negedge clk);
        rst = 1'b0; mask = 8'h0F; req = 8'hF1;
        step();
        check_all("mask_load", 1'b1, 3'd0, 8'hF1, 1'b0);
        @(negedge clk);
        mask = 8'hFF; req = 8'h00;
        step();
        check_all("mask_frozen", 1'b1, 3'd0, 8'hF1, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        step();
        check_all("mask_unmask", 1'b1, 3'd7, 8'hF0, 1'b0);
        @(negedge clk);
        mask = 8'h0F; out_ready = 1'b0; req = 8'h80;
        step();
        check_all("mask_ovf", 1'b1, 3'd7, 8'hF0, 1'b1);
        @(negedge clk);
        out_ready = 1'b1; req = 8'h00;
        step();
        check_all("mask_hidden", 1'b0, 3'd0, 8'h70, 1'b1);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
